// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall controller producing PC and pipeline-register write/flush controls.
// Latency: controls are combinational from current state and inputs; state, counters, error flag are registered.
// Backpressure: a data-memory miss freezes every stage until memReady, or forever once MEM_TIMEOUT expires.
//
// Ports:
//   clock, reset            - pipeline clock, synchronous active-high reset
//   idRs, idRt, idUsesRt    - source registers of the instruction in ID
//   exMemRead, exWriteRegister, exBranchTaken - EX-stage load/destination/taken-branch info
//   memReq, memReady        - MEM-stage data-memory handshake
//   pcWrite .. memWbFlush   - write enables / NOP-insert controls for PC and pipeline registers
//   memError, state         - sticky timeout flag and FSM state (0 RUN, 1 MEM_WAIT, 2 ERROR)
//   stallCycles             - saturating count of cycles with pcWrite=0
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exWriteRegister,
  input  logic             exBranchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExWrite,
  output logic             idExFlush,
  output logic             exMemWrite,
  output logic             memWbWrite,
  output logic             memWbFlush,
  output logic             memError,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } stateT;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  stateT       stateQ, stateNext;
  logic [15:0] waitCnt, waitNext;
  logic        errNext;
  logic        freeze;
  logic        loadUse;

  // $0 is never a real producer, so a load targeting it cannot create a hazard.
  assign loadUse = exMemRead && (exWriteRegister != 5'd0) &&
                   ((exWriteRegister == idRs) || (idUsesRt && (exWriteRegister == idRt)));

  assign state = stateQ;

  always_comb begin
    stateNext  = stateQ;
    waitNext   = waitCnt;
    errNext    = memError;
    freeze     = 1'b0;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExWrite  = 1'b1;
    idExFlush  = 1'b0;
    exMemWrite = 1'b1;
    memWbWrite = 1'b1;
    memWbFlush = 1'b0;

    case (stateQ)
      RUN: begin
        if (memReq && !memReady) begin
          freeze    = 1'b1;
          stateNext = MEM_WAIT;
          waitNext  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          stateNext = RUN;
          waitNext  = 16'd0;
        end else if (waitCnt < TIMEOUT) begin
          freeze   = 1'b1;
          waitNext = 16'(waitCnt + 16'd1);
        end else begin
          freeze    = 1'b1;
          errNext   = 1'b1;
          stateNext = ERROR;
        end
      end
      // ERROR and the unused encoding 3 both hold the pipeline frozen until reset.
      default: begin
        freeze    = 1'b1;
        stateNext = ERROR;
      end
    endcase

    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExWrite  = 1'b0;
      idExFlush  = 1'b1;
      exMemWrite = 1'b0;
      memWbWrite = 1'b0;
      memWbFlush = 1'b1;
      stateNext  = RUN;
      waitNext   = 16'd0;
      errNext    = 1'b0;
    end else if (freeze) begin
      // Stages hold their contents; only MEM->WB drains a bubble so WB does not retire twice.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
      memWbWrite = 1'b0;
      memWbFlush = 1'b1;
    end else if (exBranchTaken) begin
      // Squashing ID also removes any load-use dependency it had.
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (loadUse) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ      <= RUN;
      waitCnt     <= 16'd0;
      memError    <= 1'b0;
      stallCycles <= '0;
    end else begin
      stateQ   <= stateNext;
      waitCnt  <= waitNext;
      memError <= errNext;
      if (!pcWrite && (stallCycles != {CNT_W{1'b1}})) begin
        stallCycles <= stallCycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl with a short timeout and a 4-bit stall counter.
// Control outputs are checked mid-cycle; registered outputs are checked 1 time unit after each edge.
module tb_pipeline_ctrl;

  logic       clock;
  logic       reset;
  logic [4:0] idRs, idRt, exWriteRegister;
  logic       idUsesRt, exMemRead, exBranchTaken, memReq, memReady;
  logic       pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush;
  logic       exMemWrite, memWbWrite, memWbFlush, memError;
  logic [1:0] state;
  logic [3:0] stallCycles;
  logic [7:0] ctl;

  int testsRun = 0;
  int failCount = 0;

  // Control vector order: pcWrite ifIdWrite ifIdFlush idExWrite idExFlush exMemWrite memWbWrite memWbFlush
  localparam logic [7:0] CTL_RUN    = 8'hD6;
  localparam logic [7:0] CTL_RESET  = 8'h29;
  localparam logic [7:0] CTL_FREEZE = 8'h01;
  localparam logic [7:0] CTL_BRANCH = 8'hFE;
  localparam logic [7:0] CTL_LDUSE  = 8'h1E;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exWriteRegister(exWriteRegister), .exBranchTaken(exBranchTaken),
    .memReq(memReq), .memReady(memReady),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExWrite(idExWrite), .idExFlush(idExFlush), .exMemWrite(exMemWrite),
    .memWbWrite(memWbWrite), .memWbFlush(memWbFlush),
    .memError(memError), .state(state), .stallCycles(stallCycles)
  );

  assign ctl = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbWrite, memWbFlush};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b0;
    exMemRead = 1'b0; exWriteRegister = 5'd0; exBranchTaken = 1'b0;
    memReq = 1'b0; memReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;
    #2;
    checkVal("reset_ctl", 32'(ctl), 32'(CTL_RESET));
    cycle();
    cycle();
    checkVal("reset_state", 32'(state), 32'd0);
    checkVal("reset_err", 32'(memError), 32'd0);
    checkVal("reset_cnt", 32'(stallCycles), 32'd0);
    reset = 1'b0;
    #1;
    checkVal("idle_ctl", 32'(ctl), 32'(CTL_RUN));
    cycle();
    checkVal("idle_cnt", 32'(stallCycles), 32'd0);

    // Load-use on rs: one bubble, then the load has moved to MEM.
    exMemRead = 1'b1; exWriteRegister = 5'd5; idRs = 5'd5;
    #1;
    checkVal("lduse_ctl", 32'(ctl), 32'(CTL_LDUSE));
    cycle();
    exMemRead = 1'b0;
    #1;
    checkVal("after_bubble_ctl", 32'(ctl), 32'(CTL_RUN));
    checkVal("lduse_cnt", 32'(stallCycles), 32'd1);
    cycle();

    // Load targeting $0 never stalls.
    exMemRead = 1'b1; exWriteRegister = 5'd0; idRs = 5'd0;
    #1;
    checkVal("ld_zero_ctl", 32'(ctl), 32'(CTL_RUN));
    // rt match ignored when ID does not read rt, honoured when it does.
    exWriteRegister = 5'd7; idRt = 5'd7; idRs = 5'd3; idUsesRt = 1'b0;
    #1;
    checkVal("rt_unused_ctl", 32'(ctl), 32'(CTL_RUN));
    idUsesRt = 1'b1;
    #1;
    checkVal("rt_used_ctl", 32'(ctl), 32'(CTL_LDUSE));
    // Taken branch overrides the load-use bubble.
    exBranchTaken = 1'b1;
    #1;
    checkVal("branch_lduse_ctl", 32'(ctl), 32'(CTL_BRANCH));
    cycle();
    checkVal("branch_cnt", 32'(stallCycles), 32'd1);
    idle();

    // Three-cycle memory wait, released together with a taken branch.
    memReq = 1'b1; memReady = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checkVal($sformatf("memwait_ctl%0d", i), 32'(ctl), 32'(CTL_FREEZE));
      cycle();
      checkVal($sformatf("memwait_state%0d", i), 32'(state), 32'd1);
    end
    memReady = 1'b1; exBranchTaken = 1'b1;
    #1;
    checkVal("release_ctl", 32'(ctl), 32'(CTL_BRANCH));
    cycle();
    checkVal("release_state", 32'(state), 32'd0);
    checkVal("release_cnt", 32'(stallCycles), 32'd4);
    exBranchTaken = 1'b0;
    // Zero-wait access in RUN.
    #1;
    checkVal("zero_wait_ctl", 32'(ctl), 32'(CTL_RUN));
    cycle();
    checkVal("zero_wait_state", 32'(state), 32'd0);
    checkVal("zero_wait_cnt", 32'(stallCycles), 32'd4);

    // Timeout: 5 frozen cycles with MEM_TIMEOUT=4, then ERROR.
    memReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      checkVal($sformatf("to_ctl%0d", i), 32'(ctl), 32'(CTL_FREEZE));
      cycle();
      checkVal($sformatf("to_state%0d", i), 32'(state), (i == 5) ? 32'd2 : 32'd1);
      checkVal($sformatf("to_err%0d", i), 32'(memError), (i == 5) ? 32'd1 : 32'd0);
    end
    checkVal("to_cnt", 32'(stallCycles), 32'd9);
    // ERROR ignores memReady; counter saturates at 15.
    memReady = 1'b1; memReq = 1'b0;
    #1;
    checkVal("error_ctl", 32'(ctl), 32'(CTL_FREEZE));
    for (int i = 0; i < 20; i++) cycle();
    checkVal("error_state", 32'(state), 32'd2);
    checkVal("error_err", 32'(memError), 32'd1);
    checkVal("sat_cnt", 32'(stallCycles), 32'd15);

    reset = 1'b1;
    #1;
    checkVal("err_reset_ctl", 32'(ctl), 32'(CTL_RESET));
    cycle();
    reset = 1'b0;
    checkVal("err_reset_state", 32'(state), 32'd0);
    checkVal("err_reset_err", 32'(memError), 32'd0);
    checkVal("err_reset_cnt", 32'(stallCycles), 32'd0);

    // Reset in the middle of MEM_WAIT.
    memReq = 1'b1; memReady = 1'b0;
    cycle();
    cycle();
    checkVal("mid_wait_state", 32'(state), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0; memReq = 1'b0;
    #1;
    checkVal("mid_reset_state", 32'(state), 32'd0);
    checkVal("mid_reset_ctl", 32'(ctl), 32'(CTL_RUN));
    checkVal("mid_reset_cnt", 32'(stallCycles), 32'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline. It generates the write-enable and flush (bubble-insert) controls for the PC and the if_id, id_ex, ex_mem and mem_wb pipeline registers. It handles three cases: load-use hazards, taken-branch squashes, and multi-cycle data-memory accesses through a req/ready handshake with a timeout. It also maintains a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 255, max MEM_WAIT cycles before error; legal range 1..65535
CNT_W, 16, width of stallCycles counter

Ports:
clock  input  1  pipeline clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
idRs  input  5  rs field of instruction in ID
idRt  input  5  rt field of instruction in ID
idUsesRt  input  1  ID instruction reads rt
exMemRead  input  1  instruction in EX is a load (from id_ex control bits)
exWriteRegister  input  5  destination register of EX instruction
exBranchTaken  input  1  branch/jump in EX resolved taken this cycle
memReq  input  1  MEM-stage instruction accesses data memory
memReady  input  1  data memory completes access this cycle
pcWrite  output  1  PC load enable
ifIdWrite  output  1  if_id load enable
ifIdFlush  output  1  if_id loads NOP
idExWrite  output  1  id_ex load enable
idExFlush  output  1  id_ex loads NOP (all control bits 0)
exMemWrite  output  1  ex_mem load enable
memWbWrite  output  1  mem_wb load enable
memWbFlush  output  1  mem_wb loads NOP
memError  output  1  sticky timeout flag
state  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR
stallCycles  output  CNT_W  count of cycles with pcWrite=0

Behaviour:
- Registered: state, wait counter (16 b), memError, stallCycles. All control outputs are combinational from state and inputs (same-cycle control of the pipeline registers).
- Reset cycle (reset=1):
  - All *Write outputs = 0; all *Flush outputs = 1.
  - Next state RUN; wait counter = 0; memError = 0; stallCycles = 0.
- A flush has effect only in a cycle where the corresponding write enable is 1, except memWbFlush, which acts alone.
- RUN, evaluated in priority order:
  1. Memory stall: memReq=1 and memReady=0.
     - All *Write = 0; memWbFlush = 1; other flushes = 0.
     - Next state MEM_WAIT; wait counter = 1.
     - Branch and load-use decisions are deferred, because the stages are frozen and their inputs hold.
  2. Branch: exBranchTaken=1.
     - All *Write = 1; ifIdFlush = 1; idExFlush = 1.
     - A load-use condition in the same cycle is ignored, since the ID instruction is squashed.
  3. Load-use: exMemRead=1, exWriteRegister != 0, and (exWriteRegister == idRs, or idUsesRt=1 and exWriteRegister == idRt).
     - pcWrite = 0; ifIdWrite = 0; idExWrite = 1 with idExFlush = 1.
     - exMemWrite = 1; memWbWrite = 1.
     - Exactly one bubble: next cycle the load is in MEM and the condition is false.
  4. Otherwise: all *Write = 1; all flushes = 0.
  - memReq=1 with memReady=1 in RUN is a zero-wait access: no stall.
- MEM_WAIT:
  - memReady=1: outputs as in RUN with the memory condition treated false; priority 2..4 apply. Next state RUN; wait counter = 0.
  - memReady=0 and wait counter < MEM_TIMEOUT: freeze as in RUN case 1; wait counter increments.
  - memReady=0 and wait counter == MEM_TIMEOUT: freeze; memError <= 1; next state ERROR.
- ERROR: all *Write = 0; memWbFlush = 1; remains until reset; memReady ignored.
- stallCycles increments in every non-reset cycle where pcWrite=0, including ERROR. It saturates at all-ones (no wrap).
- Reset asserted mid-MEM_WAIT or in ERROR: the reset-cycle values apply that cycle; RUN follows.
- The state encoding value 3 is unreachable; it decodes as ERROR.

Test Plan:
- Load-use: EX lw, exWriteRegister=5; ID idRs=5 -> one cycle with pcWrite=0, ifIdWrite=0, idExFlush=1; next cycle all writes 1; stallCycles=1.
- Load to $0: exMemRead=1, exWriteRegister=0, idRs=0 -> no stall, all writes 1. Same check with idUsesRt=0 and idRt match -> no stall.
- Branch and load-use in the same cycle: exBranchTaken=1 plus load-use match -> pcWrite=1, ifIdFlush=1, idExFlush=1; stallCycles unchanged.
- Memory wait: memReq=1, memReady low for 3 cycles then high.
  - Cycles 1-3: state=1 with all writes 0.
  - Cycle 4: release, with all writes 1; state returns to 0.
  - stallCycles=3.
  - Zero-wait memReq+memReady -> no stall.
- Timeout: MEM_TIMEOUT=4, memReady held 0 -> memError=1 and state=2 after the 5th stall cycle; ERROR persists with memReady=1. Reset -> state=0, memError=0, stallCycles=0.
- Saturation: CNT_W=4, hold ERROR for 20 cycles -> stallCycles stays at 15. Reset in the middle of MEM_WAIT -> the next cycle is in RUN with all writes 1.
